adc_request_arbiter: RTL and testbench

- Shares one serial ADC read engine (chip select, clock divider, 12-bit shift-in) between NUM_REQ requesters, such as data collectors or twin-comparison monitors.
- Selects one requester at a time using round-robin arbitration and issues a start with that requester's channel.
- Waits for the engine's done pulse, then returns the 12-bit sample tagged with the requester ID.
- Enforces a minimum idle gap between conversions and a watchdog timeout.

---
 rtl/adc_request_arbiter.sv | 127 ++++++++++++
 tb/tb_adc_request_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_request_arbiter.sv
// Round-robin arbiter sharing one serial ADC read engine between NUM_REQ requesters.
// Returns each 12-bit sample tagged with the requester ID, or an error response on timeout.
module adc_request_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = 2,
   parameter int CH_W           = 2,
   parameter int GAP_CYCLES     = 50,
   parameter int TIMEOUT_CYCLES = 2000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ*CH_W-1:0] req_ch,
   output logic [NUM_REQ-1:0]      grant,
   output logic                    rsp_valid,
   output logic [ID_W-1:0]         rsp_id,
   output logic [11:0]             rsp_data,
   output logic                    rsp_err,
   output logic                    adc_start,
   output logic [CH_W-1:0]         adc_ch,
   input  logic                    adc_done,
   input  logic [11:0]             adc_sample,
   output logic                    busy
);

   // state | meaning
   // IDLE  | arbitrate pending requests
   // START | one-cycle adc_start pulse with the latched channel
   // WAIT  | wait for adc_done or timeout, then respond
   // GAP   | enforced idle time before the next arbitration
   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   state_t            state, state_nxt;
   logic [ID_W-1:0]   last_id, cur_id, win_id;
   logic              found;
   logic [GAP_W-1:0]  gap_cnt;
   logic [TO_W-1:0]   timeout_cnt;
   logic              to_tc;
   logic              wait_exit;

   assign to_tc     = (timeout_cnt >= TO_W'(TIMEOUT_CYCLES - 1));
   assign wait_exit = adc_done || to_tc;

   // First set request searching upward from last_id+1, wrapping
   always_comb begin
      int idx;
      found  = 1'b0;
      win_id = '0;
      idx    = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_id) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found  = 1'b1;
            win_id = ID_W'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (found) state_nxt = S_START;
         S_START: state_nxt = S_WAIT;
         S_WAIT:  if (wait_exit) state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
         S_GAP:   if (gap_cnt == '0) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      adc_start = (state == S_START);
      busy      = (state != S_IDLE);
   end

   // The GAP state runs until gap_cnt has drained to zero, so the next
   // adc_start lands GAP_CYCLES+2 cycles after the response strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_id     <= ID_W'(NUM_REQ - 1);
         cur_id      <= '0;
         adc_ch      <= '0;
         gap_cnt     <= '0;
         timeout_cnt <= '0;
         grant       <= '0;
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
      end else begin
         grant     <= '0;
         rsp_valid <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (found) begin
                  cur_id      <= win_id;
                  adc_ch      <= req_ch[int'(win_id)*CH_W +: CH_W];
                  timeout_cnt <= '0;
               end
            end
            S_START: timeout_cnt <= timeout_cnt + TO_W'(1);
            S_WAIT: begin
               timeout_cnt <= timeout_cnt + TO_W'(1);
               if (wait_exit) begin
                  rsp_valid <= 1'b1;
                  grant     <= NUM_REQ'(1) << cur_id;
                  rsp_id    <= cur_id;
                  rsp_data  <= adc_done ? adc_sample : 12'h000;
                  rsp_err   <= !adc_done;
                  last_id   <= cur_id;
                  gap_cnt   <= GAP_W'(GAP_CYCLES);
               end
            end
            S_GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_request_arbiter.sv
// Directed self-checking bench for adc_request_arbiter with default parameters.
module tb_adc_request_arbiter;

   localparam int TO  = 2000;
   localparam int GAP = 50;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [7:0]  req_ch;
   logic [3:0]  grant;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [11:0] rsp_data;
   logic        rsp_err;
   logic        adc_start;
   logic [1:0]  adc_ch;
   logic        adc_done;
   logic [11:0] adc_sample;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   adc_request_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_ch     (req_ch),
      .grant      (grant),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .adc_start  (adc_start),
      .adc_ch     (adc_ch),
      .adc_done   (adc_done),
      .adc_sample (adc_sample),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; req = '0; adc_done = 1'b0; adc_sample = '0;
      tick; tick;
      rst = 1'b0;
   endtask

   task automatic wait_idle;
      int n = 0;
      while (busy !== 1'b0 && n < 200) begin tick; n++; end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle busy=%b want 0", busy); end
   endtask

   task automatic test_reset;
      req_ch = '0;
      do_reset;
      checks++;
      if ({grant, rsp_valid, rsp_id, rsp_data, rsp_err, adc_start, adc_ch, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs grant=%b v=%b id=%0d data=%h err=%b start=%b ch=%0d busy=%b want all 0",
                  grant, rsp_valid, rsp_id, rsp_data, rsp_err, adc_start, adc_ch, busy);
      end
      tick;
      checks++;
      if (busy !== 1'b0 || adc_start !== 1'b0) begin
         errors++; $display("FAIL idle_no_req busy=%b start=%b want 0 0", busy, adc_start);
      end
   endtask

   task automatic test_single;
      int bad = 0;
      req_ch = 8'b0000_0010;
      req    = 4'b0001;
      tick;
      checks++;
      if (adc_start !== 1'b1 || adc_ch !== 2'd2 || busy !== 1'b1) begin
         errors++; $display("FAIL single_start start=%b ch=%0d busy=%b want 1 2 1", adc_start, adc_ch, busy);
      end
      tick;
      checks++;
      if (adc_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse start=%b want 0", adc_start); end
      repeat (29) begin tick; if (rsp_valid !== 1'b0) bad++; end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL single_early_rsp count=%0d want 0", bad); end
      adc_done = 1'b1; adc_sample = 12'hABC;
      tick;
      adc_done = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || grant !== 4'b0001 || rsp_id !== 2'd0 || rsp_data !== 12'hABC || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL single_rsp v=%b grant=%b id=%0d data=%h err=%b want 1 0001 0 abc 0",
                  rsp_valid, grant, rsp_id, rsp_data, rsp_err);
      end
      req = '0;
      tick;
      checks++;
      if (rsp_valid !== 1'b0 || grant !== 4'b0000) begin
         errors++; $display("FAIL single_rsp_pulse v=%b grant=%b want 0 0000", rsp_valid, grant);
      end
      wait_idle;
   endtask

   task automatic test_round_robin;
      int exp_order [5] = '{0, 1, 2, 3, 0};
      int prev = 0;
      int waited;
      logic [3:0]  exp_grant;
      logic [11:0] exp_data;
      do_reset;
      req_ch = {2'd3, 2'd2, 2'd1, 2'd0};
      req    = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         waited = 0;
         while (adc_start !== 1'b1 && waited < 100) begin tick; waited++; end
         checks++;
         if (adc_start !== 1'b1) begin
            errors++; $display("FAIL rr_start_timeout n=%0d start=%b want 1", n, adc_start);
            break;
         end
         checks++;
         if (adc_ch !== 2'(exp_order[n])) begin
            errors++; $display("FAIL rr_ch n=%0d ch=%0d want %0d", n, adc_ch, exp_order[n]);
         end
         if (n > 0) begin
            checks++;
            if (cyc - prev != GAP + 13) begin
               errors++; $display("FAIL rr_spacing n=%0d got=%0d want %0d", n, cyc - prev, GAP + 13);
            end
         end
         prev = cyc;
         repeat (10) tick;
         adc_done = 1'b1; adc_sample = 12'h100 + 12'(n);
         tick;
         adc_done  = 1'b0;
         exp_grant = 4'b0001 << exp_order[n];
         exp_data  = 12'h100 + 12'(n);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_order[n]) || grant !== exp_grant ||
             rsp_data !== exp_data || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rr_rsp n=%0d v=%b id=%0d grant=%b data=%h err=%b want 1 %0d %b %h 0",
                     n, rsp_valid, rsp_id, grant, rsp_data, rsp_err, exp_order[n], exp_grant, exp_data);
         end
      end
      req = '0;
      wait_idle;
   endtask

   task automatic test_timeout;
      int bad = 0;
      req_ch = 8'b0001_0000;
      req    = 4'b0100;
      tick;
      checks++;
      if (adc_start !== 1'b1 || adc_ch !== 2'd1) begin
         errors++; $display("FAIL to_start start=%b ch=%0d want 1 1", adc_start, adc_ch);
      end
      repeat (TO - 1) begin tick; if (rsp_valid !== 1'b0) bad++; end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL to_early_rsp count=%0d want 0", bad); end
      tick;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_err !== 1'b1 || rsp_data !== 12'h000 || grant !== 4'b0100) begin
         errors++;
         $display("FAIL to_rsp v=%b id=%0d err=%b data=%h grant=%b want 1 2 1 000 0100",
                  rsp_valid, rsp_id, rsp_err, rsp_data, grant);
      end
      req = '0;
      tick;
      adc_done = 1'b1; adc_sample = 12'h555;
      tick;
      adc_done = 1'b0;
      bad = 0;
      if (rsp_valid !== 1'b0) bad++;
      repeat (48) begin tick; if (rsp_valid !== 1'b0) bad++; end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL to_late_done_rsp count=%0d want 0", bad); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL to_busy_in_gap busy=%b want 1", busy); end
      tick;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL to_busy_after_gap busy=%b want 0", busy); end
   endtask

   task automatic test_collision;
      int bad = 0;
      req_ch = 8'b0000_1100;
      req    = 4'b0010;
      tick;
      checks++;
      if (adc_start !== 1'b1 || adc_ch !== 2'd3) begin
         errors++; $display("FAIL col_start start=%b ch=%0d want 1 3", adc_start, adc_ch);
      end
      repeat (TO - 1) begin tick; if (rsp_valid !== 1'b0) bad++; end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL col_early_rsp count=%0d want 0", bad); end
      adc_done = 1'b1; adc_sample = 12'h7E5;
      tick;
      adc_done = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 12'h7E5 || rsp_id !== 2'd1) begin
         errors++;
         $display("FAIL col_rsp v=%b err=%b data=%h id=%0d want 1 0 7e5 1", rsp_valid, rsp_err, rsp_data, rsp_id);
      end
      req = '0;
      wait_idle;
   endtask

   task automatic test_mid_reset;
      req_ch = 8'b0000_0001;
      req    = 4'b0001;
      tick;
      checks++;
      if (adc_start !== 1'b1) begin errors++; $display("FAIL mr_start start=%b want 1", adc_start); end
      repeat (5) tick;
      rst = 1'b1; req = '0;
      tick;
      rst = 1'b0; adc_done = 1'b1; adc_sample = 12'hFFF;
      tick;
      adc_done = 1'b0;
      checks++;
      if ({grant, rsp_valid, rsp_id, rsp_data, rsp_err, adc_start, adc_ch, busy} !== '0) begin
         errors++;
         $display("FAIL mr_outputs grant=%b v=%b id=%0d data=%h err=%b start=%b ch=%0d busy=%b want all 0",
                  grant, rsp_valid, rsp_id, rsp_data, rsp_err, adc_start, adc_ch, busy);
      end
      req_ch = 8'b1000_0000;
      req    = 4'b1000;
      tick;
      checks++;
      if (adc_start !== 1'b1 || adc_ch !== 2'd2) begin
         errors++; $display("FAIL mr_serve_start start=%b ch=%0d want 1 2", adc_start, adc_ch);
      end
      repeat (3) tick;
      adc_done = 1'b1; adc_sample = 12'h3A5;
      tick;
      adc_done = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || grant !== 4'b1000 || rsp_data !== 12'h3A5) begin
         errors++;
         $display("FAIL mr_serve_rsp v=%b id=%0d grant=%b data=%h want 1 3 1000 3a5", rsp_valid, rsp_id, grant, rsp_data);
      end
      req = '0;
      wait_idle;
   endtask

   task automatic test_drop_and_channel;
      req_ch = 8'b0000_0100;
      req    = 4'b0010;
      tick;
      checks++;
      if (adc_start !== 1'b1 || adc_ch !== 2'd1) begin
         errors++; $display("FAIL drop_start start=%b ch=%0d want 1 1", adc_start, adc_ch);
      end
      req = '0;
      tick; tick;
      req_ch = 8'b0000_1100;
      tick;
      checks++;
      if (adc_ch !== 2'd1) begin errors++; $display("FAIL drop_ch_hold ch=%0d want 1", adc_ch); end
      repeat (4) tick;
      adc_done = 1'b1; adc_sample = 12'h321;
      tick;
      adc_done = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 12'h321 || grant !== 4'b0010 || adc_ch !== 2'd1) begin
         errors++;
         $display("FAIL drop_rsp v=%b id=%0d data=%h grant=%b ch=%0d want 1 1 321 0010 1",
                  rsp_valid, rsp_id, rsp_data, grant, adc_ch);
      end
      wait_idle;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; req = '0; req_ch = '0; adc_done = 1'b0; adc_sample = '0;
      test_reset;
      test_single;
      test_round_robin;
      test_timeout;
      test_collision;
      test_mid_reset;
      test_drop_and_channel;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
